vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48: horizontal front porch / sync / back porch, in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 SHALL have parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33: vertical front porch / sync / back porch, in lines.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port hCounter, output, 10 bits: current pixel column.
REQ-008 SHALL have port vCounter, output, 10 bits: current line.
REQ-009 SHALL have port vidOn, output, 1 bit: high while the current position is in the visible area.
REQ-010 SHALL have port hsync_n, output, 1 bit: horizontal sync, active-low.
REQ-011 SHALL have port vsync_n, output, 1 bit: vertical sync, active-low.
REQ-012 SHALL have port frameStart, output, 1 bit: one-tick pulse at position (0,0).
REQ-013 SHALL have port pixTick, output, 1 bit: high in clk cycles where outputs advance on the next edge.

Function
REQ-014 SHALL define HT = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and VT = V_ACTIVE+V_FP+V_SYNC+V_BP (525); both SHALL be ≤ 1024.
REQ-015 SHALL keep a registered horizontal FSM with states H_ACT, H_FRONT, H_SYNC, H_BACK, advancing on hCounter boundaries 0, H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC.
REQ-016 SHALL keep a registered vertical FSM with states V_ACT, V_FRONT, V_SYNC, V_BACK on the equivalent vCounter boundaries; it changes state only on a line wrap.
REQ-017 SHALL update all outputs only on a pixel tick (a clk edge where pixTick was high); otherwise every output holds.
REQ-018 On each pixel tick, hCounter SHALL increment; at HT-1 it SHALL wrap to 0 and vCounter SHALL increment in the same edge.
REQ-019 When vCounter is VT-1 and hCounter wraps, vCounter SHALL wrap to 0.
REQ-020 SHALL register vidOn, hsync_n, vsync_n and frameStart in the same edge as the counters, so they always decode the presented counter values with zero-cycle skew.
REQ-021 vidOn SHALL be 1 iff hCounter < H_ACTIVE and vCounter < V_ACTIVE.
REQ-022 hsync_n SHALL be 0 iff hCounter is in [656, 751] (H_SYNC state).
REQ-023 vsync_n SHALL be 0 iff vCounter is in [490, 491] (V_SYNC state), for the full lines including horizontal blanking.
REQ-024 frameStart SHALL be 1 for exactly one pixel tick, while the counters present (0,0).

Reset
REQ-025 On any clk edge with reset=0, regardless of pixTick or position, SHALL set hCounter=0, vCounter=0, vidOn=0, hsync_n=1, vsync_n=1, frameStart=0, pixTick=0, FSMs to H_ACT/V_ACT, and clear the internal running flag.
REQ-026 The first pixel tick after release SHALL present (0,0) with vidOn=1 and frameStart=1 without incrementing; later ticks SHALL increment per REQ-018.
REQ-027 A reset mid-frame SHALL abandon the frame; there is no partial-frame completion.

Configuration
REQ-028 With macro VGA_PIX_DIV2_EN defined, pixTick SHALL toggle every clk cycle after reset release, starting at 1, giving one pixel per 2 clk (50 MHz clk -> 25 MHz pixels).
REQ-029 Without VGA_PIX_DIV2_EN, pixTick SHALL be 1 in every cycle after reset release, giving one pixel per clk.

Verification
REQ-030 Hold reset=0 for 3 clk, then release -> after the first tick: hCounter=0, vCounter=0, vidOn=1, frameStart=1, hsync_n=1, vsync_n=1; after the next tick: hCounter=1, frameStart=0.
REQ-031 Run line 0 -> vidOn falls when hCounter goes 639->640; hsync_n=0 from 656 through 751 and 1 at 752; at 799->0, vCounter goes 0->1.
REQ-032 Run a full frame -> vsync_n=0 only for vCounter 490 and 491; vidOn=0 for all vCounter ≥ 480; (799,524)->(0,0) with a frameStart pulse.
REQ-033 Count pixel ticks between consecutive frameStart pulses -> exactly 420000 (800×525).
REQ-034 Assert reset at (300,200) -> next edge: counters 0, vidOn=0, syncs 1; after release, restart per REQ-030.
REQ-035 With VGA_PIX_DIV2_EN: hCounter advances every 2 clk and each value holds 2 clk; without it: advances every clk.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, blanking/sync FSMs and registered video strobes.
// Define VGA_PIX_DIV2_EN for one pixel per two clk cycles; default is one pixel per clk.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hCounter,
  output logic [9:0] vCounter,
  output logic       vidOn,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       frameStart,
  output logic       pixTick
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX      = 10'(HT - 1);
  localparam logic [9:0] H_FP_START = 10'(H_ACTIVE);
  localparam logic [9:0] H_SY_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BP_START = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_MAX      = 10'(VT - 1);
  localparam logic [9:0] V_FP_START = 10'(V_ACTIVE);
  localparam logic [9:0] V_SY_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BP_START = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNC_ST, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNC_ST, V_BACK} v_state_t;

  h_state_t   h_state_q, h_state_d, h_state_nxt;
  v_state_t   v_state_q, v_state_d, v_state_nxt;
  logic [9:0] h_count_q, h_count_d, h_nxt;
  logic [9:0] v_count_q, v_count_d, v_nxt;
  logic       vid_on_q, vid_on_d;
  logic       hsync_n_q, hsync_n_d;
  logic       vsync_n_q, vsync_n_d;
  logic       frame_start_q, frame_start_d;
  logic       pix_tick_q, pix_tick_d;
  logic       running_q, running_d;
  logic       line_wrap;

  always_comb begin
    h_nxt     = h_count_q;
    v_nxt     = v_count_q;
    line_wrap = 1'b0;
    // The first tick after reset presents (0,0) instead of advancing past it.
    if (running_q) begin
      if (h_count_q == H_MAX) begin
        h_nxt     = 10'd0;
        line_wrap = 1'b1;
        v_nxt     = (v_count_q == V_MAX) ? 10'd0 : v_count_q + 10'd1;
      end else begin
        h_nxt = h_count_q + 10'd1;
      end
    end

    h_state_nxt = h_state_q;
    case (h_state_q)
      H_ACT:     if (h_nxt == H_FP_START) h_state_nxt = H_FRONT;
      H_FRONT:   if (h_nxt == H_SY_START) h_state_nxt = H_SYNC_ST;
      H_SYNC_ST: if (h_nxt == H_BP_START) h_state_nxt = H_BACK;
      H_BACK:    if (h_nxt == 10'd0)      h_state_nxt = H_ACT;
    endcase

    v_state_nxt = v_state_q;
    if (line_wrap) begin
      case (v_state_q)
        V_ACT:     if (v_nxt == V_FP_START) v_state_nxt = V_FRONT;
        V_FRONT:   if (v_nxt == V_SY_START) v_state_nxt = V_SYNC_ST;
        V_SYNC_ST: if (v_nxt == V_BP_START) v_state_nxt = V_BACK;
        V_BACK:    if (v_nxt == 10'd0)      v_state_nxt = V_ACT;
      endcase
    end

    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    h_state_d     = h_state_q;
    v_state_d     = v_state_q;
    vid_on_d      = vid_on_q;
    hsync_n_d     = hsync_n_q;
    vsync_n_d     = vsync_n_q;
    frame_start_d = frame_start_q;
    running_d     = running_q;
    if (pix_tick_q) begin
      h_count_d     = h_nxt;
      v_count_d     = v_nxt;
      h_state_d     = h_state_nxt;
      v_state_d     = v_state_nxt;
      vid_on_d      = (h_state_nxt == H_ACT) && (v_state_nxt == V_ACT);
      hsync_n_d     = (h_state_nxt != H_SYNC_ST);
      vsync_n_d     = (v_state_nxt != V_SYNC_ST);
      frame_start_d = (h_nxt == 10'd0) && (v_nxt == 10'd0);
      running_d     = 1'b1;
    end

`ifdef VGA_PIX_DIV2_EN
    pix_tick_d = ~pix_tick_q;
`else
    pix_tick_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      h_count_q     <= 10'd0;
      v_count_q     <= 10'd0;
      h_state_q     <= H_ACT;
      v_state_q     <= V_ACT;
      vid_on_q      <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
      pix_tick_q    <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      vid_on_q      <= vid_on_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      frame_start_q <= frame_start_d;
      pix_tick_q    <= pix_tick_d;
      running_q     <= running_d;
    end
  end

  assign hCounter   = h_count_q;
  assign vCounter   = v_count_q;
  assign vidOn      = vid_on_q;
  assign hsync_n    = hsync_n_q;
  assign vsync_n    = vsync_n_q;
  assign frameStart = frame_start_q;
  assign pixTick    = pix_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-size generator for line-level timing and a shrunken one
// (25x15 raster) for frame-level timing, both sharing clock and reset.
`timescale 1ns/1ps
module tb_vga_timing_gen;

`ifdef VGA_PIX_DIV2_EN
  localparam int PIX_DIV = 2;
`else
  localparam int PIX_DIV = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] f_h, f_v, s_h, s_v;
  logic f_vid, f_hs, f_vs, f_fs, f_pt;
  logic s_vid, s_hs, s_vs, s_fs, s_pt;

  vga_timing_gen dut_full (
    .clk(clk), .reset(reset), .hCounter(f_h), .vCounter(f_v), .vidOn(f_vid),
    .hsync_n(f_hs), .vsync_n(f_vs), .frameStart(f_fs), .pixTick(f_pt)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_small (
    .clk(clk), .reset(reset), .hCounter(s_h), .vCounter(s_v), .vidOn(s_vid),
    .hsync_n(s_hs), .vsync_n(s_vs), .frameStart(s_fs), .pixTick(s_pt)
  );

  int checks = 0;
  int errors = 0;
  int mh, mv, sh, sv;
  bit m_run;

  // {vidOn, hsync_n, vsync_n, frameStart} expected at position (h,v)
  function automatic logic [3:0] exp_flags(int h, int v, int ha, int hf, int hs,
                                           int va, int vf, int vs);
    return {(h < ha) && (v < va), !((h >= ha + hf) && (h < ha + hf + hs)),
            !((v >= va + vf) && (v < va + vf + vs)), (h == 0) && (v == 0)};
  endfunction

  task automatic model_reset();
    m_run = 1'b0; mh = 0; mv = 0; sh = 0; sv = 0;
  endtask

  // Advance to just after the next pixel-tick edge; sample at the following negedge.
  task automatic step();
    int n = 0;
    while (f_pt !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    if (f_pt !== 1'b1) begin
      checks++; errors++;
      $display("FAIL tick_timeout: pixTick=%b, required 1 within 4 clk", f_pt);
    end
    @(negedge clk);
    if (!m_run) m_run = 1'b1;
    else begin
      if (mh == 799) begin mh = 0; mv = (mv == 524) ? 0 : mv + 1; end
      else mh++;
      if (sh == 24) begin sh = 0; sv = (sv == 14) ? 0 : sv + 1; end
      else sh++;
    end
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({f_h, f_v, f_vid, f_hs, f_vs, f_fs, f_pt} !== {10'd0, 10'd0, 5'b01100}) begin
      errors++;
      $display("FAIL reset_full: h=%0d v=%0d vid/hs/vs/fs/pt=%b%b%b%b%b, required 0 0 01100",
               f_h, f_v, f_vid, f_hs, f_vs, f_fs, f_pt);
    end
    checks++;
    if ({s_h, s_v, s_vid, s_hs, s_vs, s_fs, s_pt} !== {10'd0, 10'd0, 5'b01100}) begin
      errors++;
      $display("FAIL reset_small: h=%0d v=%0d vid/hs/vs/fs/pt=%b%b%b%b%b, required 0 0 01100",
               s_h, s_v, s_vid, s_hs, s_vs, s_fs, s_pt);
    end
  endtask

  task automatic test_first_ticks();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({f_h, f_vid, f_fs} !== {10'd0, 2'b00}) begin
      errors++;
      $display("FAIL release_hold: h=%0d vid=%b fs=%b, required 0 0 0", f_h, f_vid, f_fs);
    end
    step();
    checks++;
    if ({f_h, f_v, f_vid, f_hs, f_vs, f_fs} !== {10'd0, 10'd0, 4'b1111}) begin
      errors++;
      $display("FAIL first_tick: h=%0d v=%0d vid/hs/vs/fs=%b%b%b%b, required 0 0 1111",
               f_h, f_v, f_vid, f_hs, f_vs, f_fs);
    end
    checks++;
    if ({s_h, s_v, s_vid, s_fs} !== {10'd0, 10'd0, 2'b11}) begin
      errors++;
      $display("FAIL first_tick_small: h=%0d v=%0d vid=%b fs=%b, required 0 0 1 1",
               s_h, s_v, s_vid, s_fs);
    end
    step();
    checks++;
    if ({f_h, f_v, f_fs} !== {10'd1, 10'd0, 1'b0}) begin
      errors++;
      $display("FAIL second_tick: h=%0d v=%0d fs=%b, required 1 0 0", f_h, f_v, f_fs);
    end
  endtask

  task automatic test_line0();
    int n = 0;
    while (!(mh == 0 && mv == 1) && n < 900) begin
      step();
      n++;
      checks++;
      if ({f_h, f_v, f_vid, f_hs, f_vs, f_fs} !==
          {10'(mh), 10'(mv), exp_flags(mh, mv, 640, 16, 96, 480, 10, 2)}) begin
        errors++;
        $display("FAIL line0_model: h=%0d v=%0d flags=%b%b%b%b, required %0d %0d %b",
                 f_h, f_v, f_vid, f_hs, f_vs, f_fs, mh, mv,
                 exp_flags(mh, mv, 640, 16, 96, 480, 10, 2));
      end
      if (mh == 639 || mh == 640) begin
        checks++;
        if (f_vid !== (mh == 639)) begin
          errors++;
          $display("FAIL vid_edge: h=%0d vidOn=%b, required %b", f_h, f_vid, mh == 639);
        end
      end
      if (mh == 655 || mh == 656 || mh == 751 || mh == 752) begin
        checks++;
        if (f_hs !== (mh == 655 || mh == 752)) begin
          errors++;
          $display("FAIL hsync_edge: h=%0d hsync_n=%b, required %b", f_h, f_hs,
                   mh == 655 || mh == 752);
        end
      end
    end
    checks++;
    if ({f_h, f_v} !== {10'd0, 10'd1}) begin
      errors++;
      $display("FAIL line_wrap: h=%0d v=%0d, required 0 1", f_h, f_v);
    end
  endtask

  task automatic test_frame();
    int n = 0, count = 0, vs_low = 0;
    logic [9:0] prev_h, prev_v;
    while (s_fs !== 1'b1 && n < 400) begin step(); n++; end
    prev_h = s_h; prev_v = s_v;
    n = 0;
    do begin
      prev_h = s_h; prev_v = s_v;
      step();
      count++; n++;
      if (s_vs === 1'b0) vs_low++;
      checks++;
      if ({s_h, s_v, s_vid, s_hs, s_vs, s_fs} !==
          {10'(sh), 10'(sv), exp_flags(sh, sv, 16, 2, 3, 8, 2, 2)}) begin
        errors++;
        $display("FAIL frame_model: h=%0d v=%0d flags=%b%b%b%b, required %0d %0d %b",
                 s_h, s_v, s_vid, s_hs, s_vs, s_fs, sh, sv,
                 exp_flags(sh, sv, 16, 2, 3, 8, 2, 2));
      end
    end while (s_fs !== 1'b1 && n < 500);
    checks++;
    if (count != 375) begin
      errors++;
      $display("FAIL frame_period: ticks=%0d, required 375", count);
    end
    checks++;
    if (vs_low != 50) begin
      errors++;
      $display("FAIL vsync_width: ticks=%0d, required 50", vs_low);
    end
    checks++;
    if ({prev_h, prev_v} !== {10'd24, 10'd14}) begin
      errors++;
      $display("FAIL frame_wrap: last=(%0d,%0d), required (24,14)", prev_h, prev_v);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    while (mh != 700 && n < 900) begin step(); n++; end
    checks++;
    if ({f_h, f_hs} !== {10'd700, 1'b0}) begin
      errors++;
      $display("FAIL pre_reset: h=%0d hsync_n=%b, required 700 0", f_h, f_hs);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({f_h, f_v, f_vid, f_hs, f_vs, f_fs, f_pt} !== {10'd0, 10'd0, 5'b01100}) begin
      errors++;
      $display("FAIL mid_reset: h=%0d v=%0d vid/hs/vs/fs/pt=%b%b%b%b%b, required 0 0 01100",
               f_h, f_v, f_vid, f_hs, f_vs, f_fs, f_pt);
    end
    checks++;
    if ({s_h, s_v, s_vid, s_hs, s_vs} !== {10'd0, 10'd0, 3'b011}) begin
      errors++;
      $display("FAIL mid_reset_small: h=%0d v=%0d vid/hs/vs=%b%b%b, required 0 0 011",
               s_h, s_v, s_vid, s_hs, s_vs);
    end
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    step();
    checks++;
    if ({f_h, f_v, f_vid, f_hs, f_vs, f_fs} !== {10'd0, 10'd0, 4'b1111}) begin
      errors++;
      $display("FAIL restart: h=%0d v=%0d vid/hs/vs/fs=%b%b%b%b, required 0 0 1111",
               f_h, f_v, f_vid, f_hs, f_vs, f_fs);
    end
    step();
    checks++;
    if ({f_h, f_fs} !== {10'd1, 1'b0}) begin
      errors++;
      $display("FAIL restart_next: h=%0d fs=%b, required 1 0", f_h, f_fs);
    end
  endtask

  task automatic test_pix_rate();
    int changes = 0, pt_high = 0;
    logic [9:0] start_h, prev_h;
    start_h = f_h;
    prev_h = f_h;
    repeat (20) begin
      if (f_pt === 1'b1) pt_high++;
      @(negedge clk);
      if (f_h !== prev_h) changes++;
      prev_h = f_h;
    end
    checks++;
    if (changes != 20 / PIX_DIV) begin
      errors++;
      $display("FAIL pix_rate: changes=%0d in 20 clk, required %0d", changes, 20 / PIX_DIV);
    end
    checks++;
    if (pt_high != 20 / PIX_DIV) begin
      errors++;
      $display("FAIL pixtick_duty: high=%0d of 20, required %0d", pt_high, 20 / PIX_DIV);
    end
    checks++;
    if (f_h - start_h !== 10'(20 / PIX_DIV)) begin
      errors++;
      $display("FAIL pix_advance: delta=%0d, required %0d", f_h - start_h, 20 / PIX_DIV);
    end
  endtask

  initial begin
    test_reset();
    test_first_ticks();
    test_line0();
    test_frame();
    test_mid_reset();
    test_pix_rate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
